// File: rtl/pwm_fade_pkg.sv
// Shared definitions for the PWM fade sequencer: register map, CTRL bit
// positions and the breathing-sequence state encoding.
package pwm_fade_pkg;

    localparam int FADE_CTRL_ADDR     = 'h05;
    localparam int FADE_STEP_ADDR     = 'h06;
    localparam int FADE_PRESCALE_ADDR = 'h07;
    localparam int FADE_HOLD_ADDR     = 'h08;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_ONESHOT_BIT = 1;

    typedef enum logic [2:0] {
        FADE_IDLE    = 3'd0,
        FADE_UP      = 3'd1,
        FADE_HOLD_HI = 3'd2,
        FADE_DOWN    = 3'd3,
        FADE_HOLD_LO = 3'd4
    } fade_state_e;

endpackage

// File: rtl/pwm_fade_tick.sv
// Step-tick generator: a base divider chained into a programmable prescaler.
// One tick is produced every BASE_DIV*(prescale+1) clocks while running.
module pwm_fade_tick
    import pwm_fade_pkg::*;
#(
    parameter int BASE_DIV = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       run,
    input  logic [7:0] prescale,
    output logic       tick
);

    localparam int BW = $clog2(BASE_DIV);

    logic [BW-1:0] base_cnt;
    logic [7:0]    pre_cnt;
    logic          base_wrap;
    logic          pre_wrap;

    // The prescaler wraps on >= so a prescale value lowered mid-period
    // cannot leave the counter stranded above its new terminal count.
    assign base_wrap = (base_cnt == BW'(BASE_DIV - 1));
    assign pre_wrap  = (pre_cnt >= prescale);
    assign tick      = run && base_wrap && pre_wrap;

    // Counters sit at zero while idle or being cleared, otherwise free-run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_cnt <= '0;
            pre_cnt  <= 8'd0;
        end else if (clear || !run) begin
            base_cnt <= '0;
            pre_cnt  <= 8'd0;
        end else if (base_wrap) begin
            base_cnt <= '0;
            pre_cnt  <= pre_wrap ? 8'd0 : pre_cnt + 8'd1;
        end else begin
            base_cnt <= base_cnt + BW'(1);
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Duty-cycle controller between the SPI register block and the PWM.
// Passes the SPI duty cycle through when idle; when enabled it drives a
// breathing ramp (up, hold high, down, hold low), continuous or one-shot.
module pwm_fade_sequencer
    import pwm_fade_pkg::*;
#(
    parameter int BASE_DIV = 256,
    parameter int ADDR_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [7:0]        spi_duty_cycle,
    output logic [7:0]        pwm_duty_cycle,
    output logic              fade_active,
    output logic              fade_done
);

    fade_state_e state;
    fade_state_e next_state;

    logic       ctrl_en;
    logic       ctrl_oneshot;
    logic [7:0] step_reg;
    logic [7:0] prescale_reg;
    logic [7:0] hold_reg;

    logic [7:0] level;
    logic [7:0] next_level;
    logic [7:0] hold_cnt;
    logic [7:0] next_hold;
    logic       done_next;
    logic       start;
    logic       tick;

    logic       wr_ctrl;
    logic       wr_step;
    logic       wr_prescale;
    logic       wr_hold;

    logic [7:0] step_eff;
    logic [8:0] up_sum;
    logic [7:0] up_level;
    logic [7:0] down_level;

    assign wr_ctrl     = wr_valid && (wr_addr == ADDR_W'(FADE_CTRL_ADDR));
    assign wr_step     = wr_valid && (wr_addr == ADDR_W'(FADE_STEP_ADDR));
    assign wr_prescale = wr_valid && (wr_addr == ADDR_W'(FADE_PRESCALE_ADDR));
    assign wr_hold     = wr_valid && (wr_addr == ADDR_W'(FADE_HOLD_ADDR));

    // A zero step would stall the ramp forever, so it behaves as one.
    assign step_eff   = (step_reg == 8'd0) ? 8'd1 : step_reg;
    assign up_sum     = {1'b0, level} + {1'b0, step_eff};
    assign up_level   = up_sum[8] ? 8'hFF : up_sum[7:0];
    assign down_level = (level > step_eff) ? (level - step_eff) : 8'd0;

    assign fade_active = (state != FADE_IDLE);

    pwm_fade_tick #(
        .BASE_DIV (BASE_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start),
        .run      (fade_active),
        .prescale (prescale_reg),
        .tick     (tick)
    );

    // Config registers; a completed one-shot drops EN so it can be re-armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en      <= 1'b0;
            ctrl_oneshot <= 1'b0;
            step_reg     <= 8'h01;
            prescale_reg <= 8'h00;
            hold_reg     <= 8'h00;
        end else begin
            if (done_next) begin
                ctrl_en <= 1'b0;
            end else if (wr_ctrl) begin
                ctrl_en <= wr_data[CTRL_EN_BIT];
            end
            if (wr_ctrl) begin
                ctrl_oneshot <= wr_data[CTRL_ONESHOT_BIT];
            end
            if (wr_step) begin
                step_reg <= wr_data;
            end
            if (wr_prescale) begin
                prescale_reg <= wr_data;
            end
            if (wr_hold) begin
                hold_reg <= wr_data;
            end
        end
    end

    // Sequence FSM: a disabling CTRL write outranks a same-cycle tick.
    always_comb begin
        next_state = state;
        next_level = level;
        next_hold  = hold_cnt;
        done_next  = 1'b0;
        start      = 1'b0;
        if (state == FADE_IDLE) begin
            next_level = 8'h00;
            if (wr_ctrl && wr_data[CTRL_EN_BIT] && !ctrl_en) begin
                start      = 1'b1;
                next_state = FADE_UP;
            end
        end else if (wr_ctrl && !wr_data[CTRL_EN_BIT]) begin
            next_state = FADE_IDLE;
            next_level = 8'h00;
        end else if (tick) begin
            case (state)
                FADE_UP: begin
                    next_level = up_level;
                    if (up_level == 8'hFF) begin
                        next_state = FADE_HOLD_HI;
                        next_hold  = hold_reg;
                    end
                end
                FADE_HOLD_HI: begin
                    if (hold_cnt == 8'd0) begin
                        next_state = FADE_DOWN;
                    end else begin
                        next_hold = hold_cnt - 8'd1;
                    end
                end
                FADE_DOWN: begin
                    next_level = down_level;
                    if (down_level == 8'd0) begin
                        if (ctrl_oneshot) begin
                            next_state = FADE_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            next_state = FADE_HOLD_LO;
                            next_hold  = hold_reg;
                        end
                    end
                end
                FADE_HOLD_LO: begin
                    if (hold_cnt == 8'd0) begin
                        next_state = FADE_UP;
                    end else begin
                        next_hold = hold_cnt - 8'd1;
                    end
                end
                default: begin
                    next_state = FADE_IDLE;
                    next_level = 8'h00;
                end
            endcase
        end
    end

    // State, level and the registered outputs toward the PWM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FADE_IDLE;
            level          <= 8'h00;
            hold_cnt       <= 8'h00;
            pwm_duty_cycle <= 8'h00;
            fade_done      <= 1'b0;
        end else begin
            state          <= next_state;
            level          <= next_level;
            hold_cnt       <= next_hold;
            fade_done      <= done_next;
            pwm_duty_cycle <= (state == FADE_IDLE) ? spi_duty_cycle : next_level;
        end
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench for pwm_fade_sequencer: directed scenarios plus
// randomized fade configurations compared against a tick-level model.
module tb_pwm_fade_sequencer;

    localparam int BASE_DIV = 4;
    localparam int ADDR_W   = 7;

    logic              clk;
    logic              rst_n;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        spi_duty_cycle;
    logic [7:0]        pwm_duty_cycle;
    logic              fade_active;
    logic              fade_done;

    int checkCount = 0;
    int passCount  = 0;
    int expSeq[$];

    pwm_fade_sequencer #(
        .BASE_DIV (BASE_DIV),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .spi_duty_cycle (spi_duty_cycle),
        .pwm_duty_cycle (pwm_duty_cycle),
        .fade_active    (fade_active),
        .fade_done      (fade_done)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no finish, expected finish before limit");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One register write; the write lands on the posedge inside this task.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    // Output value seen after each step tick, derived from the ramp rules.
    task automatic buildSeq(input int step, input int hold, input bit oneshot,
                            input int maxTicks, output int doneTick);
        int lvl;
        int s;
        s = (step == 0) ? 1 : step;
        expSeq.delete();
        doneTick = -1;
        lvl = 0;
        while (expSeq.size() < maxTicks && doneTick < 0) begin
            do begin
                lvl = (lvl + s > 255) ? 255 : lvl + s;
                expSeq.push_back(lvl);
            end while (lvl != 255);
            repeat (hold + 1) expSeq.push_back(255);
            do begin
                lvl = (lvl - s < 0) ? 0 : lvl - s;
                expSeq.push_back(lvl);
            end while (lvl != 0);
            if (oneshot) doneTick = expSeq.size();
            else repeat (hold + 1) expSeq.push_back(0);
        end
    endtask

    // Configure, enable, and follow the output cycle by cycle.
    task automatic runFade(input int step, input int pre, input int hold, input bit oneshot,
                           input logic [7:0] spi, input int maxTicks, input bit doCfg,
                           input string tag);
        int period;
        int doneTick;
        int total;
        int k;
        period = BASE_DIV * (pre + 1);
        spi_duty_cycle = spi;
        if (doCfg) begin
            applyStimulus(7'h06, 8'(step));
            applyStimulus(7'h07, 8'(pre));
            applyStimulus(7'h08, 8'(hold));
        end
        buildSeq(step, hold, oneshot, maxTicks, doneTick);
        applyStimulus(7'h05, {6'b0, oneshot, 1'b1});
        total = (doneTick >= 0) ? doneTick * period : maxTicks * period;
        for (int m = 1; m <= total; m++) begin
            @(posedge clk);
            #1;
            k = m / period;
            checkOutput({tag, "_pwm"}, 32'(pwm_duty_cycle), (k == 0) ? 32'd0 : 32'(expSeq[k-1]));
            if (m < total || doneTick < 0) begin
                checkOutput({tag, "_active"}, 32'(fade_active), 32'd1);
                checkOutput({tag, "_nodone"}, 32'(fade_done), 32'd0);
            end
        end
        if (doneTick >= 0) begin
            checkOutput({tag, "_done_pulse"}, 32'(fade_done), 32'd1);
            checkOutput({tag, "_done_idle"}, 32'(fade_active), 32'd0);
            @(posedge clk);
            #1;
            checkOutput({tag, "_revert"}, 32'(pwm_duty_cycle), 32'(spi));
            checkOutput({tag, "_done_end"}, 32'(fade_done), 32'd0);
        end
    endtask

    initial begin
        int rStep;
        int rPre;
        int rHold;
        bit rOne;
        logic [7:0] rSpi;

        rst_n          = 1'b0;
        wr_valid       = 1'b0;
        wr_addr        = '0;
        wr_data        = 8'h00;
        spi_duty_cycle = 8'h5A;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pwm", 32'(pwm_duty_cycle), 32'd0);
        checkOutput("rst_active", 32'(fade_active), 32'd0);
        checkOutput("rst_done", 32'(fade_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through
        @(posedge clk);
        #1;
        checkOutput("pass_5a", 32'(pwm_duty_cycle), 32'h5A);
        checkOutput("pass_active", 32'(fade_active), 32'd0);
        spi_duty_cycle = 8'h33;
        @(posedge clk);
        #1;
        checkOutput("pass_33", 32'(pwm_duty_cycle), 32'h33);

        // Continuous fade, then disable
        $display("[TB] continuous fade");
        runFade(8'h40, 0, 1, 1'b0, 8'h11, 14, 1'b1, "cont");
        applyStimulus(7'h05, 8'h00);
        checkOutput("cont_stop_active", 32'(fade_active), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("cont_stop_pwm", 32'(pwm_duty_cycle), 32'h11);

        // One-shot
        $display("[TB] one-shot fade");
        runFade(8'h80, 0, 0, 1'b1, 8'h22, 100, 1'b1, "oneshot");

        // Abort on the same cycle as a tick while at level 0xC0
        $display("[TB] abort on tick");
        spi_duty_cycle = 8'h44;
        applyStimulus(7'h06, 8'h40);
        applyStimulus(7'h08, 8'h00);
        applyStimulus(7'h05, 8'h01);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("abort_pre_level", 32'(pwm_duty_cycle), 32'hC0);
        applyStimulus(7'h05, 8'h00);
        checkOutput("abort_idle", 32'(fade_active), 32'd0);
        checkOutput("abort_no_done", 32'(fade_done), 32'd0);
        checkOutput("abort_no_update", 32'(pwm_duty_cycle == 8'hFF), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("abort_pwm", 32'(pwm_duty_cycle), 32'h44);
        checkOutput("abort_no_done2", 32'(fade_done), 32'd0);

        // Stray addresses, then prescale 2 with STEP=0
        $display("[TB] prescale and step zero");
        applyStimulus(7'h04, 8'h01);
        applyStimulus(7'h09, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stray_no_start", 32'(fade_active), 32'd0);
        applyStimulus(7'h06, 8'h00);
        applyStimulus(7'h07, 8'h02);
        applyStimulus(7'h08, 8'h00);
        applyStimulus(7'h04, 8'h40);
        applyStimulus(7'h09, 8'h40);
        runFade(0, 2, 0, 1'b0, 8'h00, 6, 1'b0, "prescale");
        applyStimulus(7'h05, 8'h00);

        // Reset during HOLD_HI
        $display("[TB] reset mid-sequence");
        spi_duty_cycle = 8'h77;
        applyStimulus(7'h06, 8'hFF);
        applyStimulus(7'h07, 8'h00);
        applyStimulus(7'h08, 8'h03);
        applyStimulus(7'h05, 8'h01);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("holdhi_level", 32'(pwm_duty_cycle), 32'hFF);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pwm", 32'(pwm_duty_cycle), 32'd0);
        checkOutput("midrst_active", 32'(fade_active), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("postrst_active", 32'(fade_active), 32'd0);
        checkOutput("postrst_pwm", 32'(pwm_duty_cycle), 32'h77);
        runFade(1, 0, 0, 1'b1, 8'h21, 1000, 1'b0, "defaults");

        // Randomized configurations
        for (int i = 0; i < 6; i++) begin
            rStep = $urandom_range(20, 255);
            rPre  = $urandom_range(0, 2);
            rHold = $urandom_range(0, 3);
            rOne  = 1'($urandom_range(0, 1));
            rSpi  = 8'($urandom);
            $display("[TB] random run %0d: step=%0d pre=%0d hold=%0d oneshot=%0d",
                     i, rStep, rPre, rHold, rOne);
            runFade(rStep, rPre, rHold, rOne, rSpi, 25, 1'b1, $sformatf("rand%0d", i));
            if (!rOne) applyStimulus(7'h05, 8'h00);
            repeat (2) @(posedge clk);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
